// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT single-wire reader.
package dht_pkg;

   localparam int FRAME_BITS = 40;
   localparam int BYTE_W     = 8;

   typedef enum logic [2:0] {
      IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_NORESP = 2'd1;
   localparam logic [1:0] ERR_BITTO  = 2'd2;
   localparam logic [1:0] ERR_CSUM   = 2'd3;

   typedef struct packed {
      logic [BYTE_W-1:0] hum_int;
      logic [BYTE_W-1:0] hum_dec;
      logic [BYTE_W-1:0] temp_int;
      logic [BYTE_W-1:0] temp_dec;
   } dht_data_t;

   // Byte sum wraps at 8 bits by construction of the operand widths.
   function automatic logic csum_ok(input logic [FRAME_BITS-1:0] f);
      logic [BYTE_W-1:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return s == f[7:0];
   endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer for the DHT line with registered-edge pulse outputs.
module dht_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic dht_i,
   output logic ln,
   output logic rise,
   output logic fall
);

   logic meta, prev;

   // Idle line is pulled up, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b1;
         ln   <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= dht_i;
         ln   <= meta;
         prev <= ln;
      end
   end

   assign rise = ln & ~prev;
   assign fall = ~ln & prev;

endmodule

// File: rtl/dht_reader.sv
// DHT sensor protocol engine: start pulse, response check, 40-bit capture, checksum.
module dht_reader
   import dht_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int START_LOW_CYC  = 1_900_000,
   parameter int BIT_THRESH_CYC = 4_000,
   parameter int TIMEOUT_CYC    = 12_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dht_i,
   output logic              dht_oe,
   input  logic              start,
   output logic              busy,
   output logic              valid,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [BYTE_W-1:0] hum_int,
   output logic [BYTE_W-1:0] hum_dec,
   output logic [BYTE_W-1:0] temp_int,
   output logic [BYTE_W-1:0] temp_dec
);

   // Counter sized to hold 20 ms of clock cycles.
   localparam int CNT_W = $clog2(CLK_HZ / 50 + 1);
   localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] TO_END    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] THRESH    = CNT_W'(BIT_THRESH_CYC);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [FRAME_BITS-1:0] sr;
   logic [5:0]            nbits;
   dht_data_t             data;
   logic                  ln, rise, fall, phase_edge;

   dht_line_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .dht_i (dht_i),
      .ln    (ln),
      .rise  (rise),
      .fall  (fall)
   );

   // Low phases end on a rise, high phases end on a fall.
   assign phase_edge = (state == RESP_LOW || state == BIT_LOW) ? rise : fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         dht_oe   <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         error    <= 1'b0;
         err_code <= ERR_NONE;
         sr       <= '0;
         nbits    <= '0;
         data     <= '0;
      end else begin
         valid <= 1'b0;
         if (cnt != '1) cnt <= cnt + 1'b1;
         case (state)
            IDLE: if (start) begin
               state    <= START_LOW;
               cnt      <= '0;
               dht_oe   <= 1'b1;
               busy     <= 1'b1;
               error    <= 1'b0;
               err_code <= ERR_NONE;
               sr       <= '0;
               nbits    <= '0;
            end
            START_LOW: if (cnt == START_END) begin
               state  <= WAIT_RESP;
               cnt    <= '0;
               dht_oe <= 1'b0;
            end
            WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: begin
               if (phase_edge) begin
                  cnt <= '0;
                  case (state)
                     WAIT_RESP: state <= RESP_LOW;
                     RESP_LOW:  state <= RESP_HIGH;
                     RESP_HIGH: state <= BIT_LOW;
                     BIT_LOW:   state <= BIT_HIGH;
                     BIT_HIGH: begin
                        sr    <= {sr[FRAME_BITS-2:0], cnt >= THRESH};
                        nbits <= nbits + 1'b1;
                        state <= (nbits == 6'(FRAME_BITS - 1)) ? CHECK : BIT_LOW;
                     end
                     default: state <= IDLE;
                  endcase
               end else if (cnt == TO_END) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= (state == BIT_LOW || state == BIT_HIGH) ? ERR_BITTO : ERR_NORESP;
               end
            end
            CHECK: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
               if (csum_ok(sr)) begin
                  data  <= dht_data_t'(sr[FRAME_BITS-1:BYTE_W]);
                  valid <= 1'b1;
               end else begin
                  error    <= 1'b1;
                  err_code <= ERR_CSUM;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign hum_int  = data.hum_int;
   assign hum_dec  = data.hum_dec;
   assign temp_int = data.temp_int;
   assign temp_dec = data.temp_dec;

endmodule

// File: tb/tb_dht_reader.sv
// Scoreboard bench for dht_reader driving a behavioural DHT sensor on a scaled timebase.
module tb_dht_reader;

   localparam int SL = 100;   // host start-pulse cycles
   localparam int TH = 20;    // bit threshold cycles
   localparam int TO = 60;    // phase timeout cycles

   localparam int M_OK = 0, M_STUCK = 1, M_RST = 2, M_BUSY = 3, M_NOSENS = 4;

   logic       clk = 1'b0, rst = 1'b0, start = 1'b0, sens = 1'b1;
   logic       dht_i, dht_oe, busy, valid, error;
   logic [1:0] err_code;
   logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

   assign dht_i = dht_oe ? 1'b0 : sens;

   dht_reader #(
      .START_LOW_CYC  (SL),
      .BIT_THRESH_CYC (TH),
      .TIMEOUT_CYC    (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .dht_i    (dht_i),
      .dht_oe   (dht_oe),
      .start    (start),
      .busy     (busy),
      .valid    (valid),
      .error    (error),
      .err_code (err_code),
      .hum_int  (hum_int),
      .hum_dec  (hum_dec),
      .temp_int (temp_int),
      .temp_dec (temp_dec)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        vld;
      bit        err;
      bit [1:0]  code;
      bit [31:0] data;
   } exp_t;

   exp_t      q[$];
   int        total = 0, bad = 0;
   bit [31:0] last_good = '0;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Monitor: every completed transaction (busy falling outside reset) pops one expectation.
   initial begin : mon
      bit   pb, pend;
      exp_t e;
      pb = 0;
      pend = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pb = 0;
            pend = 0;
         end else begin
            if (pend) begin
               chk("valid_one_cycle", valid, 0);
               pend = 0;
            end
            if (pb && !busy) begin
               chk("exp_pending", q.size() > 0, 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk("valid", valid, e.vld);
                  chk("error", error, e.err);
                  chk("err_code", err_code, e.code);
                  chk("data", {hum_int, hum_dec, temp_int, temp_dec}, e.data);
                  chk("oe_released", dht_oe, 0);
                  pend = 1;
               end
            end
            pb = busy;
         end
      end
   end

   task automatic hold(input bit lvl, input int n, input bit pulse = 0);
      sens = lvl;
      for (int i = 0; i < n; i++) begin
         if (pulse && i == 5) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (busy && n < 3000) begin
         n++;
         @(negedge clk);
      end
      chk("done_in_time", busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_frame(input bit [39:0] f, input int mode, input int arg);
      exp_t e;
      int   n, sum;
      sum = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
      if (mode == M_NOSENS) begin
         e = '{0, 1, 2'd1, last_good};
         q.push_back(e);
      end else if (mode == M_STUCK) begin
         e = '{0, 1, 2'd2, last_good};
         q.push_back(e);
      end else if (mode != M_RST) begin
         if (sum % 256 == int'(f[7:0])) begin
            last_good = f[39:8];
            e = '{1, 0, 2'd0, last_good};
         end else begin
            e = '{0, 1, 2'd3, last_good};
         end
         q.push_back(e);
      end

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (dht_oe && n < SL * 4) begin
         n++;
         @(negedge clk);
      end
      chk("oe_len", n, SL);

      if (mode == M_NOSENS) begin
         n = 0;
         while (busy && n < TO * 4) begin
            n++;
            @(negedge clk);
         end
         chk("noresp_cycles", n, TO);
         return;
      end

      hold(1, 12);
      hold(0, 40, mode == M_BUSY);
      hold(1, 40);
      for (int i = 0; i < 40; i++) begin
         hold(0, $urandom_range(28, 22), mode == M_BUSY && i == 3);
         if (mode == M_STUCK && i == arg) begin
            hold(1, 100);
            return;
         end
         if (mode == M_RST && i == arg) begin
            sens = 1'b1;
            #2 rst = 1'b0;
            #1;
            chk("rst_oe", dht_oe, 0);
            chk("rst_busy", busy, 0);
            chk("rst_error", error, 0);
            chk("rst_data", {hum_int, hum_dec, temp_int, temp_dec}, 0);
            last_good = '0;
            @(negedge clk);
            #2 rst = 1'b1;
            @(negedge clk);
            return;
         end
         hold(1, f[39-i] ? $urandom_range(38, 28) : $urandom_range(16, 10));
      end
      hold(0, 25);
      sens = 1'b1;
   endtask

   initial begin : stim
      bit [39:0] f;
      int        s;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_valid", valid, 0);
      chk("reset_error", error, 0);
      chk("reset_err_code", err_code, 0);
      chk("reset_oe", dht_oe, 0);
      chk("reset_data", {hum_int, hum_dec, temp_int, temp_dec}, 0);
      #2 rst = 1'b1;
      @(negedge clk);

      run_frame(40'h37_00_19_05_55, M_OK, 0);     wait_done();
      run_frame(40'h37_00_19_05_54, M_OK, 0);     wait_done();
      run_frame(40'h0, M_NOSENS, 0);               wait_done();
      run_frame(40'h37_00_19_05_55, M_STUCK, 17); wait_done();
      run_frame(40'h37_00_19_05_55, M_RST, 10);   wait_done();
      run_frame(40'h37_00_19_05_55, M_OK, 0);     wait_done();
      run_frame(40'hFF_FF_01_02_01, M_BUSY, 0);   wait_done();

      for (int k = 0; k < 8; k++) begin
         f[39:8] = $urandom();
         s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
         f[7:0] = ($urandom_range(1, 0) == 1) ? 8'(s % 256) : 8'($urandom());
         run_frame(f, M_OK, 0);
         wait_done();
      end

      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
